iommu_regbus_arbiter: RTL and testbench

- Shares the IOMMU 32-bit register-interface port (the input of the IOMMU register map wrapper) between N_REQ register-interface requesters, e.g. the AXI→APB→reg programming path and an internal debug/init sequencer.
- Round-robin arbitration, one outstanding transaction at a time; granted request is registered before being driven downstream.

---
 rtl/iommu_regbus_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_iommu_regbus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iommu_regbus_arbiter.sv
// ---------------------------------------------------------------------------
// iommu_regbus_arbiter
//
// Purpose:
//   Shares the single 32-bit register-interface port of the IOMMU register map
//   wrapper between N_REQ register-interface requesters. For example, these can
//   be the AXI->APB->reg programming path and an internal debug/init sequencer.
//
//   Arbitration is round-robin with one outstanding transaction at a time.
//   The granted request is registered before it is driven downstream.
//   The requester granted last has the lowest priority in the next round.
//   A back-to-back grant always passes through one IDLE cycle.
//
// Optional feature (macro IOMMU_REGBUS_ARB_TIMEOUT_EN):
//   When the macro is defined, a BUSY cycle counter completes a stalled
//   transaction locally with an error after TIMEOUT_CYCLES cycles without
//   reg_ready_i. When the macro is undefined, BUSY waits indefinitely.
//
// Ports:
//   clk_i, rst_ni      clock / asynchronous active-low reset
//   req_valid_i        per-requester valid
//   req_write_i        per-requester write(1)/read(0)
//   req_addr_i         packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i        packed write data
//   req_wstrb_i        packed byte strobes
//   rsp_ready_o        one-hot completion pulse to the granted requester
//   rsp_rdata_o        read data, broadcast, zero unless rsp_ready_o != 0
//   rsp_error_o        error, broadcast, zero unless rsp_ready_o != 0
//   reg_valid_o ..     registered downstream request
//   reg_wstrb_o
//   reg_ready_i        downstream completion
//   reg_rdata_i        downstream read data
//   reg_error_i        downstream error
//   busy_o             transaction in flight
//   grant_idx_o        index of the current or last granted requester
// ---------------------------------------------------------------------------
module iommu_regbus_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int STRB          = DATA_WIDTH / 8,
  localparam int IDX_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0]            req_write_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [N_REQ*STRB-1:0]       req_wstrb_i,
  output logic [N_REQ-1:0]            rsp_ready_o,
  output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
  output logic                        rsp_error_o,
  output logic                        reg_valid_o,
  output logic                        reg_write_o,
  output logic [ADDR_WIDTH-1:0]       reg_addr_o,
  output logic [DATA_WIDTH-1:0]       reg_wdata_o,
  output logic [STRB-1:0]             reg_wstrb_o,
  input  logic                        reg_ready_i,
  input  logic [DATA_WIDTH-1:0]       reg_rdata_i,
  input  logic                        reg_error_i,
  output logic                        busy_o,
  output logic [IDX_W-1:0]            grant_idx_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             any_req;
  logic [IDX_W-1:0] sel_idx;
  logic             timeout_hit;
  logic             done;

  assign any_req = |req_valid_i;
  assign busy_o  = (state == BUSY);

  // The round-robin search starts one past the last grant. This makes the
  // requester granted last the lowest priority. Reset parks grant_idx_o at
  // N_REQ-1, so requester 0 wins first.
  always_comb begin
    logic found;
    int   idx;
    found   = 1'b0;
    sel_idx = grant_idx_o;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(grant_idx_o) + i) % N_REQ;
      if (!found && req_valid_i[idx]) begin
        found   = 1'b1;
        sel_idx = IDX_W'(idx);
      end
    end
  end

`ifdef IOMMU_REGBUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt;

  // Holding the counter at zero outside BUSY means it starts cleared on every
  // entry into BUSY. It saturates at CNT_LAST, which is the cycle where the
  // transaction is completed locally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt <= '0;
    end else if (state != BUSY) begin
      to_cnt <= '0;
    end else if (!reg_ready_i && (to_cnt != CNT_LAST)) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // If a real ready arrives in the final cycle, it wins over the local timeout.
  assign timeout_hit = (state == BUSY) && !reg_ready_i && (to_cnt == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  assign done = (state == BUSY) && (reg_ready_i || timeout_hit);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Requests arriving while BUSY are only sampled on the
  // following IDLE cycle, which creates the one-cycle bubble between grants.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any_req) state_next = BUSY;
      BUSY: if (done)    state_next = IDLE;
      default:           state_next = IDLE;
    endcase
  end

  // The downstream request is captured once, on the grant edge, and then held
  // stable while BUSY. This holds even if the requester drops valid, because
  // there is no abort.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_valid_o <= 1'b0;
      reg_write_o <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wstrb_o <= '0;
      grant_idx_o <= IDX_W'(N_REQ - 1);
    end else if (state == IDLE) begin
      if (any_req) begin
        reg_valid_o <= 1'b1;
        reg_write_o <= req_write_i[sel_idx];
        reg_addr_o  <= req_addr_i[int'(sel_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        reg_wdata_o <= req_wdata_i[int'(sel_idx)*DATA_WIDTH +: DATA_WIDTH];
        reg_wstrb_o <= req_wstrb_i[int'(sel_idx)*STRB +: STRB];
        grant_idx_o <= sel_idx;
      end
    end else if (done) begin
      reg_valid_o <= 1'b0;
    end
  end

  // The response path is combinational from reg_ready_i so that completion is
  // reported in the same cycle. Data and error are forced to zero outside the
  // completion pulse. A local timeout reports an error with zero data.
  always_comb begin
    rsp_ready_o = '0;
    rsp_rdata_o = '0;
    rsp_error_o = 1'b0;
    if (done) begin
      rsp_ready_o[grant_idx_o] = 1'b1;
      if (reg_ready_i) begin
        rsp_rdata_o = reg_rdata_i;
        rsp_error_o = reg_error_i;
      end else begin
        rsp_error_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iommu_regbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iommu_regbus_arbiter
//
// Directed testbench for iommu_regbus_arbiter with N_REQ=2, 32-bit
// address/data and TIMEOUT_CYCLES=8.
// Inputs are driven at the falling edge. Outputs are sampled 1 time unit
// later, well away from the rising edge.
// Cycle n denotes the half-period after the n-th rising edge that follows the
// cycle in which a request was first presented.
// ---------------------------------------------------------------------------
module tb_iommu_regbus_arbiter;

  localparam int N_REQ = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;

  logic                 clk_i;
  logic                 rst_ni;
  logic [N_REQ-1:0]     req_valid_i;
  logic [N_REQ-1:0]     req_write_i;
  logic [N_REQ*AW-1:0]  req_addr_i;
  logic [N_REQ*DW-1:0]  req_wdata_i;
  logic [N_REQ*SW-1:0]  req_wstrb_i;
  logic [N_REQ-1:0]     rsp_ready_o;
  logic [DW-1:0]        rsp_rdata_o;
  logic                 rsp_error_o;
  logic                 reg_valid_o;
  logic                 reg_write_o;
  logic [AW-1:0]        reg_addr_o;
  logic [DW-1:0]        reg_wdata_o;
  logic [SW-1:0]        reg_wstrb_o;
  logic                 reg_ready_i;
  logic [DW-1:0]        reg_rdata_i;
  logic                 reg_error_i;
  logic                 busy_o;
  logic [0:0]           grant_idx_o;

  int checkCount;
  int failCount;

  iommu_regbus_arbiter #(
    .N_REQ(N_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_ready_o(rsp_ready_o), .rsp_rdata_o(rsp_rdata_o), .rsp_error_o(rsp_error_o),
    .reg_valid_o(reg_valid_o), .reg_write_o(reg_write_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i),
    .busy_o(busy_o), .grant_idx_o(grant_idx_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Counts one comparison and reports it if the observed value differs from
  // the expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Sets up the request fields of one requester.
  task automatic applyStimulus(input int k, input logic valid, input logic write,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb);
    req_valid_i[k]          = valid;
    req_write_i[k]          = write;
    req_addr_i[k*AW +: AW]  = addr;
    req_wdata_i[k*DW +: DW] = wdata;
    req_wstrb_i[k*SW +: SW] = wstrb;
  endtask

  // Clears all inputs, pulses reset, and returns at a falling edge with reset
  // released.
  task automatic applyReset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_write_i = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    reg_ready_i = 1'b0;
    reg_rdata_i = '0;
    reg_error_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic nextCycle();
    @(negedge clk_i);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;

    // ---------------- Reset state ----------------
    applyReset();
    #1;
    checkOutput("rst_reg_valid", 32'(reg_valid_o), 32'h0);
    checkOutput("rst_busy",      32'(busy_o),      32'h0);
    checkOutput("rst_grant",     32'(grant_idx_o), 32'h1);
    checkOutput("rst_rsp_ready", 32'(rsp_ready_o), 32'h0);
    checkOutput("rst_addr",      reg_addr_o,       32'h0);

    // ---------------- Single read ----------------
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
    nextCycle(); #1;                                   // cycle 1
    checkOutput("rd_c1_valid", 32'(reg_valid_o), 32'h1);
    checkOutput("rd_c1_addr",  reg_addr_o,       32'h0000_0010);
    checkOutput("rd_c1_write", 32'(reg_write_o), 32'h0);
    checkOutput("rd_c1_grant", 32'(grant_idx_o), 32'h0);
    checkOutput("rd_c1_busy",  32'(busy_o),      32'h1);
    nextCycle();                                       // cycle 2
    reg_rdata_i = 32'h1111_2222;
    #1;
    checkOutput("rd_c2_valid", 32'(reg_valid_o), 32'h1);
    checkOutput("rd_c2_rsp",   32'(rsp_ready_o), 32'h0);
    checkOutput("rd_c2_rdata_zero", rsp_rdata_o, 32'h0);
    nextCycle();                                       // cycle 3
    reg_ready_i = 1'b1;
    reg_rdata_i = 32'hDEAD_BEEF;
    #1;
    checkOutput("rd_c3_valid", 32'(reg_valid_o), 32'h1);
    checkOutput("rd_c3_rsp",   32'(rsp_ready_o), 32'h1);
    checkOutput("rd_c3_rdata", rsp_rdata_o,      32'hDEAD_BEEF);
    checkOutput("rd_c3_err",   32'(rsp_error_o), 32'h0);
    nextCycle();                                       // cycle 4
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reg_ready_i = 1'b0;
    #1;
    checkOutput("rd_c4_valid", 32'(reg_valid_o), 32'h0);
    checkOutput("rd_c4_busy",  32'(busy_o),      32'h0);
    checkOutput("rd_c4_rsp",   32'(rsp_ready_o), 32'h0);

    // ---------------- Contention ----------------
    applyReset();
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0100, 32'hAAAA_0000, 4'h3);
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_0200, 32'h5555_1111, 4'hC);
    reg_ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      nextCycle(); #1;
      if (k % 2 == 1) begin
        int g;
        g = ((k - 1) / 2) % 2;
        checkOutput($sformatf("cont_c%0d_valid", k), 32'(reg_valid_o), 32'h1);
        checkOutput($sformatf("cont_c%0d_grant", k), 32'(grant_idx_o), 32'(g));
        checkOutput($sformatf("cont_c%0d_rsp", k),   32'(rsp_ready_o), 32'(1 << g));
        checkOutput($sformatf("cont_c%0d_wdata", k), reg_wdata_o,
                    (g == 0) ? 32'hAAAA_0000 : 32'h5555_1111);
        checkOutput($sformatf("cont_c%0d_wstrb", k), 32'(reg_wstrb_o),
                    (g == 0) ? 32'h3 : 32'hC);
        checkOutput($sformatf("cont_c%0d_addr", k),  reg_addr_o,
                    (g == 0) ? 32'h100 : 32'h200);
      end else begin
        checkOutput($sformatf("cont_c%0d_valid", k), 32'(reg_valid_o), 32'h0);
        checkOutput($sformatf("cont_c%0d_rsp", k),   32'(rsp_ready_o), 32'h0);
      end
    end

    // ---------------- Error pass-through ----------------
    applyReset();
    applyStimulus(1, 1'b1, 1'b1, 32'h0000_0048, 32'h1234_5678, 4'hF);
    nextCycle(); #1;
    checkOutput("err_grant", 32'(grant_idx_o), 32'h1);
    checkOutput("err_write", 32'(reg_write_o), 32'h1);
    checkOutput("err_addr",  reg_addr_o,       32'h48);
    checkOutput("err_wstrb", 32'(reg_wstrb_o), 32'hF);
    checkOutput("err_wdata", reg_wdata_o,      32'h1234_5678);
    reg_ready_i = 1'b1;
    reg_error_i = 1'b1;
    #1;
    checkOutput("err_rsp",   32'(rsp_ready_o), 32'h2);
    checkOutput("err_flag",  32'(rsp_error_o), 32'h1);
    nextCycle();
    applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reg_ready_i = 1'b0;
    reg_error_i = 1'b1;
    #1;
    checkOutput("err_idle_flag", 32'(rsp_error_o), 32'h0);

    // ---------------- Valid drop while BUSY ----------------
    applyReset();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0030, 32'h0, 4'h0);
    nextCycle(); #1;                                   // cycle 1
    checkOutput("drop_c1_grant", 32'(grant_idx_o), 32'h0);
    nextCycle();                                       // cycle 2
    req_valid_i[0] = 1'b0;
    #1;
    checkOutput("drop_c2_busy", 32'(busy_o),     32'h1);
    checkOutput("drop_c2_addr", reg_addr_o,      32'h20);
    nextCycle();                                       // cycle 3
    reg_ready_i = 1'b1;
    #1;
    checkOutput("drop_c3_rsp",  32'(rsp_ready_o), 32'h1);
    nextCycle();                                       // cycle 4
    reg_ready_i = 1'b0;
    #1;
    checkOutput("drop_c4_valid", 32'(reg_valid_o), 32'h0);
    nextCycle(); #1;                                   // cycle 5
    checkOutput("drop_c5_grant", 32'(grant_idx_o), 32'h1);
    checkOutput("drop_c5_addr",  reg_addr_o,       32'h30);
    checkOutput("drop_c5_valid", 32'(reg_valid_o), 32'h1);

    // ---------------- Timeout / indefinite wait ----------------
    applyReset();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_0060, 32'h0, 4'h0);
    reg_rdata_i = 32'hFFFF_FFFF;
`ifdef IOMMU_REGBUS_ARB_TIMEOUT_EN
    for (int k = 1; k <= 7; k++) begin
      nextCycle(); #1;
      checkOutput($sformatf("to_c%0d_rsp", k), 32'(rsp_ready_o), 32'h0);
    end
    nextCycle(); #1;                                   // cycle 8
    checkOutput("to_c8_rsp",   32'(rsp_ready_o), 32'h1);
    checkOutput("to_c8_err",   32'(rsp_error_o), 32'h1);
    checkOutput("to_c8_rdata", rsp_rdata_o,      32'h0);
    nextCycle();
    req_valid_i[0] = 1'b0;
    #1;
    checkOutput("to_c9_valid", 32'(reg_valid_o), 32'h0);
    checkOutput("to_c9_busy",  32'(busy_o),      32'h0);
`else
    for (int k = 1; k <= 100; k++) begin
      nextCycle();
    end
    #1;
    checkOutput("noto_busy",  32'(busy_o),      32'h1);
    checkOutput("noto_valid", 32'(reg_valid_o), 32'h1);
    checkOutput("noto_rsp",   32'(rsp_ready_o), 32'h0);
`endif

    // ---------------- Async reset during BUSY ----------------
    applyReset();
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0040, 32'hFACE_0001, 4'h5);
    nextCycle(); #1;
    checkOutput("ar_pre_grant", 32'(grant_idx_o), 32'h0);
    checkOutput("ar_pre_busy",  32'(busy_o),      32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(reg_valid_o), 32'h0);
    checkOutput("ar_write", 32'(reg_write_o), 32'h0);
    checkOutput("ar_addr",  reg_addr_o,       32'h0);
    checkOutput("ar_wdata", reg_wdata_o,      32'h0);
    checkOutput("ar_wstrb", 32'(reg_wstrb_o), 32'h0);
    checkOutput("ar_busy",  32'(busy_o),      32'h0);
    checkOutput("ar_grant", 32'(grant_idx_o), 32'h1);
    checkOutput("ar_rsp",   32'(rsp_ready_o), 32'h0);
    nextCycle();
    rst_ni = 1'b1;
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0);
    nextCycle(); #1;
    checkOutput("ar_post_grant", 32'(grant_idx_o), 32'h0);
    checkOutput("ar_post_addr",  reg_addr_o,       32'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
